// File: rtl/mux2_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter_pkg
//   Shared definitions for the two-lane round-robin mux arbiter: owner-state
//   encodings, lane index constants, the budget counter width and a helper
//   that maps a lane index onto its owner state.
// ---------------------------------------------------------------------------
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam int LANE0 = 0;
    localparam int LANE1 = 1;

    localparam int HOLD_CNT_W = 4;

    // Owner state for a given lane index.
    function automatic state_e own_state(input logic lane);
        return lane ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mux2_lane_select.sv
// ---------------------------------------------------------------------------
// mux2_lane_select
//   Combinational 2:1 lane mux. Picks one WIDTH-bit lane out of a packed
//   two-lane bus.
//
//   Ports:
//     data_i  in  2*WIDTH  packed lanes, lane i at [i*WIDTH +: WIDTH]
//     sel_i   in  1        lane index (1 selects lane 1)
//     data_o  out WIDTH    selected lane
// ---------------------------------------------------------------------------
module mux2_lane_select
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [2*WIDTH-1:0] data_i,
    input  logic               sel_i,
    output logic [WIDTH-1:0]   data_o
);

    assign data_o = sel_i ? data_i[LANE1*WIDTH +: WIDTH]
                          : data_i[LANE0*WIDTH +: WIDTH];

endmodule

// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
//   Round-robin arbiter for a shared 2:1 mux channel. Registers which lane
//   owns the mux, steers that lane to `out` under a valid/ready handshake and
//   limits each ownership to MAX_HOLD transfers while the other lane waits.
//
//   Parameters:
//     WIDTH     bits per data lane
//     MAX_HOLD  transfers per grant while the other lane requests (1..15)
//
//   Ports:
//     clk        in  1        rising-edge clock
//     rst_n      in  1        asynchronous active-low reset
//     req        in  2        per-lane request (lane holds valid data)
//     input1     in  2*WIDTH  packed lane data, lane i at [i*WIDTH +: WIDTH]
//     out_ready  in  1        downstream accepts `out` this cycle
//     grant      out 2        one-hot registered owner, 00 when idle
//     select     out 1        registered mux select
//     out        out WIDTH    lane `select` of input1 (combinational)
//     out_valid  out 1        owner is requesting (combinational)
// ---------------------------------------------------------------------------
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [2*WIDTH-1:0] input1,
    input  logic               out_ready,
    output logic [1:0]         grant,
    output logic               select,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_MAX_C  = HOLD_CNT_W'(MAX_HOLD);
    // A transfer taken at this count is the last one of the budget.
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST_C = HOLD_CNT_W'(MAX_HOLD - 1);

    state_e                state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                  last_q, last_d;
    logic                  select_q, select_d;

    logic own_lane;
    logic owner_req;
    logic other_req;
    logic xfer;

    assign grant     = {state_q == ST_OWN1, state_q == ST_OWN0};
    assign out_valid = |(grant & req);
    assign xfer      = out_valid & out_ready;
    assign select    = select_q;

    assign own_lane  = (state_q == ST_OWN1);
    assign owner_req = req[own_lane];
    assign other_req = req[~own_lane];

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                unique case (req)
                    2'b01:   state_d = ST_OWN0;
                    2'b10:   state_d = ST_OWN1;
                    2'b11:   state_d = own_state(~last_q);
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_OWN0, ST_OWN1: begin
                // Release takes precedence; it lands on the same owner as a
                // forced switch anyway when the other lane is waiting.
                if (!owner_req) begin
                    state_d = other_req ? own_state(~own_lane) : ST_IDLE;
                end else if (xfer && other_req && hold_cnt_q >= HOLD_LAST_C) begin
                    state_d = own_state(~own_lane);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        select_d   = select_q;

        if (state_d != state_q) begin
            hold_cnt_d = '0;
        end else if (xfer && hold_cnt_q < HOLD_MAX_C) begin
            // Saturates so an uncontested owner keeps streaming and a later
            // request from the other lane switches after the next beat.
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        // Pointer and select track the owner; both hold while idle.
        if (state_d == ST_OWN0) begin
            last_d   = 1'b0;
            select_d = 1'b0;
        end else if (state_d == ST_OWN1) begin
            last_d   = 1'b1;
            select_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            last_q     <= 1'b1;
            select_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            select_q   <= select_d;
        end
    end

    mux2_lane_select #(
        .WIDTH (WIDTH)
    ) u_lane_select (
        .data_i (input1),
        .sel_i  (select_q),
        .data_o (out)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_rr_arbiter
//   Directed bench for mux2_rr_arbiter (WIDTH=4, MAX_HOLD=4). Inputs change
//   on the falling edge; outputs are compared 1 time unit later, so each
//   comparison sees the state registered at the previous rising edge.
// ---------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [2*W-1:0] input1 = '0;
    logic         out_ready = 1'b1;
    logic [1:0]   grant;
    logic         select;
    logic [W-1:0] out_w;
    logic         out_valid;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]   req;
        logic [7:0]   data;
        logic         rdy;
        logic [1:0]   g;
        logic         s;
        logic         v;
        logic [3:0]   o;
    } vec_t;

    vec_t vecs [18];

    mux2_rr_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .input1    (input1),
        .out_ready (out_ready),
        .grant     (grant),
        .select    (select),
        .out       (out_w),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] g, input logic s,
                              input logic v, input logic [3:0] o);
        check({tag, ".grant"},     8'(grant),     8'(g));
        check({tag, ".select"},    8'(select),    8'(s));
        check({tag, ".out_valid"}, 8'(out_valid), 8'(v));
        check({tag, ".out"},       8'(out_w),     8'(o));
    endtask

    // One cycle: drive inputs on the falling edge, then compare.
    task automatic step(input string tag, input logic [1:0] r, input logic [7:0] d,
                        input logic rdy, input logic [1:0] g, input logic s,
                        input logic v, input logic [3:0] o);
        @(negedge clk);
        req       = r;
        input1    = d;
        out_ready = rdy;
        #1;
        check_outs(tag, g, s, v, o);
    endtask

    // Reset with both lanes requesting (outputs must still be idle), then
    // release with the given request pattern.
    task automatic do_reset(input string tag, input logic [1:0] rel_req);
        @(negedge clk);
        rst_n     = 1'b0;
        req       = 2'b11;
        input1    = 8'h96;
        out_ready = 1'b1;
        #1;
        check_outs({tag, ".in_reset"}, 2'b00, 1'b0, 1'b0, 4'h6);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = rel_req;
        #1;
        check_outs({tag, ".released"}, 2'b00, 1'b0, 1'b0, 4'h6);
    endtask

    initial begin
        // {req, data, rdy, grant, select, out_valid, out}
        vecs[0]  = '{2'b01, 8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 4'hA};
        vecs[1]  = '{2'b01, 8'h3C, 1'b1, 2'b01, 1'b0, 1'b1, 4'hC};
        vecs[2]  = '{2'b00, 8'h3C, 1'b1, 2'b01, 1'b0, 1'b0, 4'hC};
        vecs[3]  = '{2'b10, 8'h96, 1'b1, 2'b00, 1'b0, 1'b0, 4'h6};
        vecs[4]  = '{2'b10, 8'h96, 1'b1, 2'b10, 1'b1, 1'b1, 4'h9};
        vecs[5]  = '{2'b10, 8'h71, 1'b1, 2'b10, 1'b1, 1'b1, 4'h7};
        vecs[6]  = '{2'b10, 8'h71, 1'b1, 2'b10, 1'b1, 1'b1, 4'h7};
        vecs[7]  = '{2'b10, 8'h71, 1'b1, 2'b10, 1'b1, 1'b1, 4'h7};
        vecs[8]  = '{2'b10, 8'h71, 1'b1, 2'b10, 1'b1, 1'b1, 4'h7};
        vecs[9]  = '{2'b11, 8'h71, 1'b1, 2'b10, 1'b1, 1'b1, 4'h7};
        vecs[10] = '{2'b11, 8'h71, 1'b1, 2'b01, 1'b0, 1'b1, 4'h1};
        vecs[11] = '{2'b00, 8'h71, 1'b1, 2'b01, 1'b0, 1'b0, 4'h1};
        vecs[12] = '{2'b10, 8'hE2, 1'b1, 2'b00, 1'b0, 1'b0, 4'h2};
        vecs[13] = '{2'b00, 8'hE2, 1'b1, 2'b10, 1'b1, 1'b0, 4'hE};
        vecs[14] = '{2'b00, 8'hE2, 1'b1, 2'b00, 1'b1, 1'b0, 4'hE};
        vecs[15] = '{2'b11, 8'hE2, 1'b1, 2'b00, 1'b1, 1'b0, 4'hE};
        vecs[16] = '{2'b11, 8'hE2, 1'b0, 2'b01, 1'b0, 1'b1, 4'h2};
        vecs[17] = '{2'b00, 8'hE2, 1'b0, 2'b01, 1'b0, 1'b0, 4'h2};

        // Reset, then idle for 5 cycles.
        do_reset("rst_idle", 2'b00);
        for (int k = 0; k < 5; k++)
            step($sformatf("idle[%0d]", k), 2'b00, 8'h96, 1'b1, 2'b00, 1'b0, 1'b0, 4'h6);

        // Single requesters, release, saturated streaming, late contest,
        // select holding through idle, pointer-driven contest from idle.
        for (int i = 0; i < 18; i++)
            step($sformatf("tbl[%0d]", i), vecs[i].req, vecs[i].data, vecs[i].rdy,
                 vecs[i].g, vecs[i].s, vecs[i].v, vecs[i].o);

        // Contest from reset: lane 0 first, 4 beats each, no bubbles.
        do_reset("contest", 2'b11);
        for (int k = 1; k <= 16; k++) begin
            automatic logic lane = logic'(((k - 1) / 4) % 2);
            step($sformatf("contest[%0d]", k), 2'b11, 8'h96, 1'b1,
                 lane ? 2'b10 : 2'b01, lane, 1'b1, lane ? 4'h9 : 4'h6);
        end

        // Backpressure: lane 1 owner at hold_cnt=2, stalled for 6 cycles.
        do_reset("bp", 2'b11);
        for (int k = 0; k < 4; k++)
            step($sformatf("bp.own0[%0d]", k), 2'b11, 8'h96, 1'b1, 2'b01, 1'b0, 1'b1, 4'h6);
        for (int k = 0; k < 2; k++)
            step($sformatf("bp.own1[%0d]", k), 2'b11, 8'h96, 1'b1, 2'b10, 1'b1, 1'b1, 4'h9);
        for (int k = 0; k < 6; k++)
            step($sformatf("bp.stall[%0d]", k), 2'b11, 8'h96, 1'b0, 2'b10, 1'b1, 1'b1, 4'h9);
        for (int k = 0; k < 2; k++)
            step($sformatf("bp.beat[%0d]", k), 2'b11, 8'h96, 1'b1, 2'b10, 1'b1, 1'b1, 4'h9);
        step("bp.switched", 2'b11, 8'h96, 1'b1, 2'b01, 1'b0, 1'b1, 4'h6);

        // Release on contest: lane 0 owner drops while lane 1 waits; lane 1
        // then gets a full fresh budget of 4 beats.
        step("rel.drop", 2'b10, 8'h96, 1'b1, 2'b01, 1'b0, 1'b0, 4'h6);
        for (int k = 0; k < 4; k++)
            step($sformatf("rel.own1[%0d]", k), 2'b11, 8'h96, 1'b1, 2'b10, 1'b1, 1'b1, 4'h9);
        step("rel.back0", 2'b11, 8'h96, 1'b1, 2'b01, 1'b0, 1'b1, 4'h6);

        // Asynchronous reset while lane 1 owns the mux.
        step("mid.to_own1", 2'b10, 8'h96, 1'b1, 2'b01, 1'b0, 1'b0, 4'h6);
        step("mid.own1", 2'b10, 8'h96, 1'b1, 2'b10, 1'b1, 1'b1, 4'h9);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("mid.async", 2'b00, 1'b0, 1'b0, 4'h6);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 2'b11;
        #1;
        check_outs("mid.released", 2'b00, 1'b0, 1'b0, 4'h6);
        step("mid.lane0_wins", 2'b11, 8'h96, 1'b1, 2'b01, 1'b0, 1'b1, 4'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
